// File: rtl/im_loader.sv
// im_loader: boot-time writer for the TRM instruction memory.
// Receives a framed byte stream (LEN_HI, LEN_LO, then N big-endian words of
// NB bytes), assembles DW-bit words and drives the memory write port. The
// TRM core is held in reset while a load is in progress.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start               one-cycle pulse that begins a load (IDLE/DONE/ERR only)
//   rx_data/valid/ready byte stream handshake; rx_ready from state only
//   im_we/wadr/wdata    instruction memory write port, one cycle per word
//   busy                load in progress
//   cpu_rst             active-low core reset, low while busy or in reset
//   done, err           sticky outcome of the last load
module im_loader #(
  parameter int unsigned DW   = 36,
  parameter int unsigned Size = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          im_we,
  output logic [31:0]   im_wadr,
  output logic [DW-1:0] im_wdata,
  output logic          busy,
  output logic          cpu_rst,
  output logic          done,
  output logic          err
);

  localparam int unsigned NB   = (DW + 7) / 8;
  localparam int unsigned WW   = 8 * NB;
  localparam int unsigned PADW = WW - DW;
  // Padding bits occupy the top PADW bits of the first byte of each word.
  localparam logic [7:0]  PAD_MASK = 8'(16'hFF00 >> PADW);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERR
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   count;
  logic [15:0]   addr;
  logic [3:0]    bidx;
  logic [WW-1:0] word;
  logic [WW-1:0] word_sh;
  logic [15:0]   len_c;
  logic          xfer;

  logic rx_ready_nxt, im_we_nxt, busy_nxt, done_nxt, err_nxt;

  assign xfer    = rx_valid & rx_ready;
  assign len_c   = {count[15:8], rx_data};
  assign word_sh = (word << 8) | WW'(rx_data);
  assign cpu_rst = ~busy & rst;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_LEN_HI;
      S_LEN_HI: if (xfer) state_nxt = S_LEN_LO;
      S_LEN_LO: if (xfer) begin
        if (len_c == 16'd0)                 state_nxt = S_DONE;
        else if (32'(len_c) > 32'(Size))    state_nxt = S_ERR;
        else                                state_nxt = S_DATA;
      end
      S_DATA: if (xfer) begin
        if (bidx == 4'd0 && (rx_data & PAD_MASK) != 8'd0) state_nxt = S_ERR;
        else if (bidx == 4'(NB - 1))                      state_nxt = S_WRITE;
      end
      S_WRITE: begin
        if (16'(addr + 16'd1) == count) state_nxt = S_DONE;
        else                            state_nxt = S_DATA;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode of the upcoming state, registered below so that every
  // status output lines up with the state it describes.
  always_comb begin
    rx_ready_nxt = 1'b0;
    im_we_nxt    = 1'b0;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;
    case (state_nxt)
      S_LEN_HI, S_LEN_LO, S_DATA: rx_ready_nxt = 1'b1;
      S_WRITE:                    im_we_nxt    = 1'b1;
      S_DONE:                     done_nxt     = 1'b1;
      S_ERR:                      err_nxt      = 1'b1;
      default: ;
    endcase
    busy_nxt = rx_ready_nxt | im_we_nxt;
  end

  // Output registers; write address/data captured on entry to WRITE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_ready <= 1'b0;
      im_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      im_wadr  <= 32'd0;
      im_wdata <= '0;
    end else begin
      rx_ready <= rx_ready_nxt;
      im_we    <= im_we_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
      if (state == S_DATA && state_nxt == S_WRITE) begin
        im_wadr  <= 32'(addr);
        im_wdata <= DW'(word_sh);
      end
    end
  end

  // Frame datapath: length, word address, byte index and word assembly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 16'd0;
      addr  <= 16'd0;
      bidx  <= 4'd0;
      word  <= '0;
    end else begin
      case (state)
        S_LEN_HI: if (xfer) count[15:8] <= rx_data;
        S_LEN_LO: if (xfer) begin
          count[7:0] <= rx_data;
          addr       <= 16'd0;
          bidx       <= 4'd0;
        end
        S_DATA: if (xfer) begin
          word <= word_sh;
          bidx <= 4'(bidx + 4'd1);
        end
        S_WRITE: begin
          addr <= 16'(addr + 16'd1);
          bidx <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
module tb_im_loader;

  localparam int unsigned DW   = 36;
  localparam int unsigned Size = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          im_we;
  logic [31:0]   im_wadr;
  logic [DW-1:0] im_wdata;
  logic          busy;
  logic          cpu_rst;
  logic          done;
  logic          err;

  im_loader #(.DW(DW), .Size(Size)) dut (
    .clk(clk), .rst(rst), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .im_we(im_we), .im_wadr(im_wadr), .im_wdata(im_wdata),
    .busy(busy), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Instruction memory model with a fetch port (pmadr -> pmout, 1 cycle)
  logic [DW-1:0] mem [Size];
  logic [31:0]   pmadr = 32'd0;
  logic [DW-1:0] pmout;
  always @(posedge clk) begin
    if (im_we) mem[im_wadr[9:0]] <= im_wdata;
    pmout <= mem[pmadr[9:0]];
  end

  int checks = 0;
  int failures = 0;

  typedef struct { logic [31:0] adr; logic [DW-1:0] dat; } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: each write must match the head of the expected queue
  logic we_prev = 1'b0;
  always @(negedge clk) begin
    if (im_we) begin
      chk("rx_ready_in_write", {63'd0, rx_ready}, 64'd0);
      chk("we_back_to_back", {63'd0, we_prev}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'd1, 64'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("write_addr", {32'd0, im_wadr}, {32'd0, e.adr});
        chk("write_data", 64'(im_wdata), 64'(e.dat));
      end
    end
    we_prev = im_we;
  end

  logic stress = 1'b0;

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    if (stress) begin
      int gap = $urandom_range(0, 3);
      rx_valid = 1'b0;
      repeat (gap) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      start = 1'b0;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) chk("byte_accept_timeout", 64'd1, 64'd0);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", {63'd0, busy}, 64'd1);
    chk("ready_after_start", {63'd0, rx_ready}, 64'd1);
    chk("done_cleared", {62'd0, done, err}, 64'd0);
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [DW-1:0] d);
    wr_t e;
    e.adr = a;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int n = 0;
    rx_valid = 1'b0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  task automatic send_word(input logic [39:0] w);
    for (int i = 4; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic nominal_frame();
    expect_wr(32'd0, 36'h123456789);
    expect_wr(32'd1, 36'hABCDEF012);
    expect_wr(32'd2, 36'hFFFFFFFFF);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_word(40'h01_23_45_67_89);
    send_word(40'h0A_BC_DE_F0_12);
    send_word(40'h0F_FF_FF_FF_FF);
    wait_idle();
    chk("nom_done", {62'd0, done, err}, 64'd2);
    chk("nom_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("nom_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic readback(input logic [31:0] a, input logic [DW-1:0] d);
    pmadr = a;
    @(negedge clk);
    chk("fetch_readback", 64'(pmout), 64'(d));
  endtask

  task automatic check_reset_outputs();
    chk("rst_ready_we_busy", {61'd0, rx_ready, im_we, busy}, 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    chk("rst_wadr", {32'd0, im_wadr}, 64'd0);
    chk("rst_wdata", 64'(im_wdata), 64'd0);
    chk("rst_cpu_rst", {63'd0, cpu_rst}, 64'd0);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);
    chk("idle_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    chk("idle_ready", {63'd0, rx_ready}, 64'd0);

    // Bytes offered in IDLE are not accepted
    rx_valid = 1'b1; rx_data = 8'h55;
    repeat (3) @(negedge clk);
    chk("idle_no_accept", {62'd0, rx_ready, busy}, 64'd0);
    rx_valid = 1'b0;

    // Nominal load with readback through the fetch port
    nominal_frame();
    readback(32'd0, 36'h123456789);
    readback(32'd1, 36'hABCDEF012);
    readback(32'd2, 36'hFFFFFFFFF);

    // Empty frame
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h00);
    rx_valid = 1'b0;
    chk("empty_done", {61'd0, done, err, busy}, 64'd4);

    // Oversize count (1025)
    pulse_start();
    send_byte(8'h04);
    send_byte(8'h01);
    rx_valid = 1'b0;
    chk("oversize_err", {60'd0, done, err, busy, rx_ready}, 64'd4);
    repeat (3) @(negedge clk);

    // Padding error on second word
    expect_wr(32'd0, 36'h123456789);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h02);
    send_word(40'h01_23_45_67_89);
    send_byte(8'h10);
    rx_valid = 1'b0;
    chk("pad_err", {61'd0, done, err, busy}, 64'd2);
    repeat (3) @(negedge clk);
    chk("pad_one_write", 64'(exp_q.size()), 64'd0);

    // Recovery: start clears err, single-word frame loads
    expect_wr(32'd0, 36'h0000000AB);
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(40'h00_00_00_00_AB);
    wait_idle();
    chk("recover_done", {62'd0, done, err}, 64'd2);
    readback(32'd0, 36'h0000000AB);

    // Handshake stress: random gaps and start pulses while busy
    stress = 1'b1;
    nominal_frame();
    stress = 1'b0;
    readback(32'd0, 36'h123456789);
    readback(32'd1, 36'hABCDEF012);
    readback(32'd2, 36'hFFFFFFFFF);

    // Reset mid-load after byte 3 of the first word
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h03);
    send_byte(8'h01);
    send_byte(8'h23);
    send_byte(8'h45);
    rx_valid = 1'b0;
    #1 rst = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", {60'd0, done, err, busy, rx_ready}, 64'd0);
    chk("post_rst_cpu_rst", {63'd0, cpu_rst}, 64'd1);
    nominal_frame();
    readback(32'd2, 36'hFFFFFFFFF);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
